// File: rtl/riscv_pkg.sv
// +------------------------------------------------------------------+
// | riscv_pkg: shared branch types for the execute-stage resolver.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package riscv_pkg;

    localparam int RV_XLEN    = 64;
    localparam int INSN_BYTES = 4;

    // Encodings follow the funct3 field of the conditional branch opcodes
    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } branch_op_t;

    typedef enum logic [0:0] {
        BR_IDLE     = 1'b0,
        BR_REDIRECT = 1'b1
    } br_state_e;

    typedef struct packed {
        logic [RV_XLEN-1:0] pc;
        logic [RV_XLEN-1:0] target;
        logic [RV_XLEN-1:0] next_pc;
        logic               taken;
        logic               mispred;
        logic               misaligned;
    } br_result_t;

endpackage

`default_nettype wire

// File: rtl/branch_resolve_ctrl_comp.sv
// +------------------------------------------------------------------+
// | branch_comp: condition evaluator for conditional branches.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module branch_comp
    import riscv_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  branch_op_t        op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              taken
);

    always_comb begin
        taken = 1'b0;
        case (op)
            BR_EQ:   taken = (a == b);
            BR_NE:   taken = (a != b);
            BR_LT:   taken = ($signed(a) <  $signed(b));
            BR_GE:   taken = ($signed(a) >= $signed(b));
            BR_LTU:  taken = (a <  b);
            BR_GEU:  taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
// +------------------------------------------------------------------+
// | branch_resolve_ctrl: EX-stage branch resolution, redirect and    |
// | flush sequencing. Optional counters under BRANCH_STATS_EN.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module branch_resolve_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int CNT_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              br_valid_i,
    output logic              br_ready_o,
    input  branch_op_t        br_op_i,
    input  logic              br_is_jal_i,
    input  logic              br_is_jalr_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic              pred_taken_i,
    input  logic [XLEN-1:0]   pred_target_i,
    output logic              redir_valid_o,
    input  logic              redir_ready_i,
    output logic [XLEN-1:0]   redir_pc_o,
    output logic              flush_o,
    output logic              exc_valid_o,
    output logic [XLEN-1:0]   exc_tval_o,
    output logic              upd_valid_o,
    output logic [XLEN-1:0]   upd_pc_o,
    output logic [XLEN-1:0]   upd_target_o,
    output logic              upd_taken_o,
    output logic              upd_mispred_o,
    output logic [CNT_W-1:0]  stat_br_cnt_o,
    output logic [CNT_W-1:0]  stat_misp_cnt_o
);

    br_state_e  state;
    br_result_t res;
    logic       cmp_taken;
    logic       accept;

    branch_comp #(.XLEN(XLEN)) u_comp (
        .op    (br_op_i),
        .a     (rs1_i),
        .b     (rs2_i),
        .taken (cmp_taken)
    );

    // Ready is gated by rst_ni so nothing is offered while reset is held
    assign br_ready_o    = rst_ni && (state == BR_IDLE) && !flush_i;
    assign accept        = br_valid_i && br_ready_o;
    assign redir_valid_o = (state == BR_REDIRECT);

    always_comb begin
        res        = '0;
        res.pc     = pc_i;
        res.taken  = br_is_jal_i || br_is_jalr_i || cmp_taken;
        if (br_is_jalr_i)
            res.target = (rs1_i + imm_i) & ~XLEN'(1);
        else
            res.target = pc_i + imm_i;
        res.next_pc    = res.taken ? res.target : (pc_i + XLEN'(INSN_BYTES));
        res.mispred    = (res.taken != pred_taken_i) ||
                         (res.taken && (res.target != pred_target_i));
        res.misaligned = res.taken && (res.target[1:0] != 2'b00);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= BR_IDLE;
            redir_pc_o    <= '0;
            flush_o       <= 1'b0;
            exc_valid_o   <= 1'b0;
            exc_tval_o    <= '0;
            upd_valid_o   <= 1'b0;
            upd_pc_o      <= '0;
            upd_target_o  <= '0;
            upd_taken_o   <= 1'b0;
            upd_mispred_o <= 1'b0;
        end else begin
            flush_o     <= 1'b0;
            exc_valid_o <= 1'b0;
            upd_valid_o <= 1'b0;
            if (accept) begin
                upd_valid_o   <= 1'b1;
                upd_pc_o      <= res.pc;
                upd_target_o  <= res.target;
                upd_taken_o   <= res.taken;
                upd_mispred_o <= res.mispred;
                // A misaligned target traps instead of redirecting
                if (res.misaligned) begin
                    exc_valid_o <= 1'b1;
                    exc_tval_o  <= res.target;
                    flush_o     <= 1'b1;
                end else if (res.mispred) begin
                    flush_o    <= 1'b1;
                    redir_pc_o <= res.next_pc;
                    state      <= BR_REDIRECT;
                end
            end else if ((state == BR_REDIRECT) && (flush_i || redir_ready_i)) begin
                state <= BR_IDLE;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] misp_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            br_cnt   <= '0;
            misp_cnt <= '0;
        end else if (accept) begin
            if (br_cnt != '1)
                br_cnt <= br_cnt + CNT_W'(1);
            if ((res.mispred || res.misaligned) && (misp_cnt != '1))
                misp_cnt <= misp_cnt + CNT_W'(1);
        end
    end

    assign stat_br_cnt_o   = br_cnt;
    assign stat_misp_cnt_o = misp_cnt;
`else
    assign stat_br_cnt_o   = '0;
    assign stat_misp_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
// +------------------------------------------------------------------+
// | tb_branch_resolve_ctrl: scoreboard bench with randomized branches.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_branch_resolve_ctrl;
    import riscv_pkg::*;

    localparam int XLEN = 64;
`ifdef BRANCH_STATS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif

    logic clk = 1'b0;
    logic rst_ni, flush_i, br_valid_i, br_ready_o, br_is_jal_i, br_is_jalr_i;
    branch_op_t br_op_i;
    logic [XLEN-1:0] pc_i, imm_i, rs1_i, rs2_i, pred_target_i;
    logic pred_taken_i, redir_valid_o, redir_ready_i, flush_o, exc_valid_o;
    logic [XLEN-1:0] redir_pc_o, exc_tval_o, upd_pc_o, upd_target_o;
    logic upd_valid_o, upd_taken_o, upd_mispred_o;
    logic [CNT_W-1:0] stat_br_cnt_o, stat_misp_cnt_o;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .br_valid_i(br_valid_i), .br_ready_o(br_ready_o), .br_op_i(br_op_i),
        .br_is_jal_i(br_is_jal_i), .br_is_jalr_i(br_is_jalr_i),
        .pc_i(pc_i), .imm_i(imm_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
        .redir_valid_o(redir_valid_o), .redir_ready_i(redir_ready_i),
        .redir_pc_o(redir_pc_o), .flush_o(flush_o),
        .exc_valid_o(exc_valid_o), .exc_tval_o(exc_tval_o),
        .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o), .upd_target_o(upd_target_o),
        .upd_taken_o(upd_taken_o), .upd_mispred_o(upd_mispred_o),
        .stat_br_cnt_o(stat_br_cnt_o), .stat_misp_cnt_o(stat_misp_cnt_o)
    );

    typedef struct {
        int          op;
        bit          jal, jalr;
        logic [63:0] pc, imm, rs1, rs2;
        bit          pt;
        logic [63:0] ptgt;
    } stim_t;

    typedef struct {
        logic [63:0] pc, target, next_pc;
        bit          taken, mispred, exc, redir;
    } exp_t;

    exp_t  exp_q[$];
    int    n_cmp = 0, n_err = 0;
    bit    pend = 0, last_flush = 0, last_rdy = 0;
    logic [63:0] pend_pc = '0;
    longint mdl_br = 0, mdl_misp = 0;
    longint cnt_max = (longint'(1) << CNT_W) - 1;
    int    flush_pct = 0, rdy_pct = 50;
    bit    mon_en = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: outcome derived directly from the ISA branch rules
    function automatic exp_t model(stim_t s);
        exp_t e;
        logic signed [63:0] a, b;
        a = s.rs1;
        b = s.rs2;
        if (s.jal || s.jalr) e.taken = 1;
        else case (s.op)
            0: e.taken = (s.rs1 == s.rs2);
            1: e.taken = (s.rs1 != s.rs2);
            4: e.taken = (a < b);
            5: e.taken = (a >= b);
            6: e.taken = (s.rs1 < s.rs2);
            7: e.taken = (s.rs1 >= s.rs2);
            default: e.taken = 0;
        endcase
        e.pc      = s.pc;
        e.target  = s.jalr ? ((s.rs1 + s.imm) & ~64'd1) : (s.pc + s.imm);
        e.next_pc = e.taken ? e.target : (s.pc + 64'd4);
        e.mispred = (e.taken != s.pt) || (e.taken && (e.target != s.ptgt));
        e.exc     = e.taken && (e.target % 4 != 0);
        e.redir   = !e.exc && e.mispred;
        return e;
    endfunction

    function automatic logic any_out();
        return |{br_ready_o, redir_valid_o, redir_pc_o, flush_o, exc_valid_o, exc_tval_o,
                 upd_valid_o, upd_pc_o, upd_target_o, upd_taken_o, upd_mispred_o,
                 stat_br_cnt_o, stat_misp_cnt_o};
    endfunction

    // Handshake-side controls, re-randomized every cycle
    initial begin
        flush_i = 0;
        redir_ready_i = 0;
        forever begin
            @(posedge clk);
            #2;
            flush_i       = ($urandom_range(99) < flush_pct);
            redir_ready_i = ($urandom_range(99) < rdy_pct);
        end
    end

    // Monitor: pops the scoreboard whenever an update pulse is due
    always @(negedge clk) begin
        if (rst_ni && mon_en) begin
            exp_t e;
            if (pend && (last_flush || last_rdy)) pend = 0;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("upd_valid", upd_valid_o, 1);
                chk("upd_pc", upd_pc_o, e.pc);
                chk("upd_target", upd_target_o, e.target);
                chk("upd_taken", upd_taken_o, e.taken);
                chk("upd_mispred", upd_mispred_o, e.mispred);
                chk("flush_o", flush_o, e.exc || e.redir);
                chk("exc_valid", exc_valid_o, e.exc);
                if (e.exc) chk("exc_tval", exc_tval_o, e.target);
                if (e.redir) begin
                    pend    = 1;
                    pend_pc = e.next_pc;
                end
`ifdef BRANCH_STATS_EN
                if (mdl_br < cnt_max) mdl_br++;
                if ((e.mispred || e.exc) && mdl_misp < cnt_max) mdl_misp++;
`endif
            end else begin
                chk("idle_pulses", {upd_valid_o, flush_o, exc_valid_o}, 0);
            end
            chk("redir_valid", redir_valid_o, pend);
            if (pend) chk("redir_pc", redir_pc_o, pend_pc);
            chk("stat_br_cnt", stat_br_cnt_o, mdl_br);
            chk("stat_misp_cnt", stat_misp_cnt_o, mdl_misp);
            last_flush = flush_i;
            last_rdy   = redir_ready_i;
        end
    end

    // Presents one branch and holds it until the model says it is accepted
    task automatic issue(stim_t s);
        bit done = 0;
        @(posedge clk);
        #2;
        br_valid_i = 1; br_op_i = branch_op_t'(s.op[2:0]);
        br_is_jal_i = s.jal; br_is_jalr_i = s.jalr;
        pc_i = s.pc; imm_i = s.imm; rs1_i = s.rs1; rs2_i = s.rs2;
        pred_taken_i = s.pt; pred_target_i = s.ptgt;
        for (int k = 0; k < 60 && !done; k++) begin
            bit mdl_ready;
            @(negedge clk);
            #1;
            mdl_ready = rst_ni && !pend && !flush_i;
            chk("br_ready", br_ready_o, mdl_ready);
            if (mdl_ready) begin
                exp_q.push_back(model(s));
                done = 1;
            end else begin
                @(posedge clk);
                #2;
            end
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(int n);
        @(posedge clk);
        #2;
        br_valid_i = 0;
        repeat (n - 1) @(posedge clk);
    endtask

    function automatic stim_t mk(int op, bit jal, bit jalr, logic [63:0] pc, logic [63:0] imm,
                                 logic [63:0] rs1, logic [63:0] rs2, bit pt, logic [63:0] ptgt);
        stim_t s;
        s.op = op; s.jal = jal; s.jalr = jalr; s.pc = pc; s.imm = imm;
        s.rs1 = rs1; s.rs2 = rs2; s.pt = pt; s.ptgt = ptgt;
        return s;
    endfunction

    function automatic logic [63:0] rnd_opnd();
        case ($urandom_range(3))
            0: return 64'd0;
            1: return '1;
            2: return 64'd1;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        exp_t  e;
        int    ops[6] = '{0, 1, 4, 5, 6, 7};
        int    kind = $urandom_range(7);
        s.op   = ops[$urandom_range(5)];
        s.jal  = (kind == 0);
        s.jalr = (kind == 1);
        s.pc   = ($urandom_range(7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 : {$urandom(), $urandom() & 32'hFFFF_FFFC};
        s.imm  = {{44{1'b0}}, 20'($urandom_range(20'hFFFFF))};
        if ($urandom_range(1) == 1) s.imm = -s.imm;
        if ($urandom_range(3) != 0) s.imm = s.imm & ~64'd3;
        s.rs1  = rnd_opnd();
        s.rs2  = ($urandom_range(3) == 0) ? s.rs1 : rnd_opnd();
        s.pt   = 0; s.ptgt = '0;
        e = model(s);
        if ($urandom_range(1) == 1) begin
            s.pt = e.taken; s.ptgt = e.target;
        end else begin
            s.pt = $urandom_range(1); s.ptgt = {$urandom(), $urandom()};
        end
        return s;
    endfunction

    stim_t d[6];

    initial begin
        rst_ni = 0; br_valid_i = 0; br_op_i = BR_EQ; br_is_jal_i = 0; br_is_jalr_i = 0;
        pc_i = '0; imm_i = '0; rs1_i = '0; rs2_i = '0; pred_taken_i = 0; pred_target_i = '0;
        d[0] = mk(0, 0, 0, 64'h1000, 64'h40, 64'd5, 64'd5, 1, 64'h1040);
        d[1] = mk(4, 0, 0, 64'h1000, 64'h40, '1, 64'd1, 0, 64'h0);
        d[2] = mk(0, 0, 1, 64'h1000, 64'h2, 64'h2001, 64'h0, 1, 64'h2000);
        d[3] = mk(0, 1, 0, 64'h1000, 64'h6, 64'h0, 64'h0, 0, 64'h0);
        d[4] = mk(7, 0, 0, 64'h1000, 64'h40, 64'h0, '1, 1, 64'h1040);
        d[5] = mk(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'h0, 64'h0, 1, 64'h4);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_br_ready", br_ready_o, 0);
        chk("reset_outputs", any_out(), 0);
        @(posedge clk);
        #2;
        rst_ni = 1;
        mon_en = 1;

        // Directed cases, no squash traffic
        flush_pct = 0;
        foreach (d[i]) issue(d[i]);
        idle(4);

        // Randomized traffic including squashes and back-pressure
        flush_pct = 10;
        for (int i = 0; i < 400; i++) begin
            issue(rnd_stim());
            if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
        end
        idle(6);

        // flush_i while a redirect is pending
        flush_pct = 0; rdy_pct = 0;
        repeat (3) @(posedge clk);
        issue(d[1]);
        idle(3);
        @(negedge clk);
        #2;
        flush_pct = 100;
        @(posedge clk);
        #3;
        flush_pct = 0;
        repeat (3) @(posedge clk);

        // Asynchronous reset in the middle of a pending redirect
        issue(d[4]);
        idle(3);
        @(negedge clk);
        #2;
        chk("redir_before_reset", redir_valid_o, 1);
        rst_ni = 0;
        #1;
        chk("async_reset_outputs", any_out(), 0);
        exp_q.delete();
        pend = 0; last_flush = 0; last_rdy = 0; mdl_br = 0; mdl_misp = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_ni = 1;
        rdy_pct = 50;
        for (int i = 0; i < 40; i++) issue(rnd_stim());
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
